div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-003 Port clk: input, 1 bit, rising-edge clock.
REQ-004 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-005 Port start: input, 1 bit, request to begin a divide; sampled only in IDLE.
REQ-006 Port signed_div: input, 1 bit; 1 = two's-complement divide (DIV), 0 = unsigned divide (DIVU).
REQ-007 Port annul: input, 1 bit, cancels an in-flight divide (exception/flush).
REQ-008 Port dividend: input, WIDTH bits, numerator; sampled with start.
REQ-009 Port divisor: input, WIDTH bits, denominator; sampled with start.
REQ-010 Port busy: output, 1 bit, pipeline stall request.
REQ-011 Port valid: output, 1 bit, one-cycle result strobe.
REQ-012 Port quotient: output, WIDTH bits, LO write value; feeds the writeback select mux.
REQ-013 Port remainder: output, WIDTH bits, HI write value; feeds the writeback select mux.
REQ-014 Port div_by_zero: output, 1 bit, flag qualified by valid.

Function
REQ-015 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-016 IDLE->BUSY SHALL occur when start=1 and annul=0; operands and signed_div SHALL be latched in that cycle.
REQ-017 On start in IDLE, the block SHALL latch magnitudes of the operands (negated when signed_div=1 and the MSB is 1) and record the quotient sign (dividend MSB xor divisor MSB) and the remainder sign (dividend MSB).
REQ-018 BUSY SHALL run exactly WIDTH restoring iterations, one per cycle, counted by a log2(WIDTH)+1-bit counter.
REQ-019 Each iteration SHALL shift {rem,quo} left by 1, trial-subtract the divisor magnitude from rem using a WIDTH+1-bit subtract, keep the difference if it is non-negative, and set the quotient LSB to 1 in that case.
REQ-020 After the final iteration the FSM SHALL enter DONE, where it SHALL apply the sign fix-ups, drive quotient/remainder registered, and assert valid for exactly one cycle.
REQ-021 Latency SHALL be WIDTH+1 cycles from the start edge to the valid cycle (33 for WIDTH=32).
REQ-022 DONE SHALL return to IDLE; a start in the DONE cycle SHALL be ignored, and the pipeline SHALL re-issue it.
REQ-023 busy SHALL be combinational: busy = (IDLE & start & ~annul) | BUSY; busy SHALL be 0 in DONE.
REQ-024 A divisor of 0 SHALL skip BUSY: IDLE->DONE next cycle, with quotient = all ones, remainder = dividend unmodified, and div_by_zero=1 with valid.
REQ-025 In a signed divide of the most-negative value by -1, the block SHALL return quotient = 0x8000_0000 and remainder = 0 with no flag.
REQ-026 annul=1 in BUSY or DONE SHALL force IDLE next cycle, suppress valid, and leave quotient/remainder unchanged.
REQ-027 start with annul=1 in the same IDLE cycle SHALL be ignored.
REQ-028 start while in BUSY SHALL be ignored and SHALL NOT re-latch the operands.
REQ-029 quotient, remainder and div_by_zero SHALL hold their last values until the next valid.

Reset
REQ-030 Asserting rst at any time, including mid-divide, SHALL immediately force IDLE, counter = 0, busy = 0, valid = 0, quotient = 0, remainder = 0 and div_by_zero = 0.
REQ-031 After rst deasserts, the first start SHALL behave as in REQ-016.

Structure
REQ-032 The shared CPU package SHALL hold the FSM state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and the constant DIV_WIDTH=32.
REQ-033 One sub-module, div_step, SHALL implement a single combinational restoring iteration (shift, trial-subtract, select), instantiated once.
REQ-034 All state SHALL live in div_unit; no multicycle paths SHALL be required.

Verification
REQ-035 Unsigned divide 100 / 7: busy high for 33 cycles, then quotient = 14, remainder = 2, valid one cycle.
REQ-036 Signed divide -7 / 2: quotient = 0xFFFF_FFFD (-3), remainder = 0xFFFF_FFFF (-1); the same operands with signed_div=0 give quotient = 0x7FFF_FFFC, remainder = 1.
REQ-037 Divide 0x1234 / 0: valid on the 2nd cycle, quotient = 0xFFFF_FFFF, remainder = 0x1234, div_by_zero = 1.
REQ-038 Signed divide 0x8000_0000 / 0xFFFF_FFFF: quotient = 0x8000_0000, remainder = 0.
REQ-039 Start 100/7, then annul at cycle 10: IDLE next cycle, no valid; a new 9/3 started afterwards gives quotient = 3, remainder = 0.
REQ-040 rst asserted at cycle 20 of a divide: outputs zero immediately with no valid; start ignored during BUSY verified by a second start at cycle 5 not altering the result.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared CPU package: divider FSM state encoding and default datapath width.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-divide iteration: shift {rem,quo}, trial-subtract, select.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           keep;

  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs};
  // A set shifted MSB already exceeds any divisor, so the borrow bit is meaningless then.
  assign keep     = shifted[WIDTH] | ~diff[WIDTH];
  assign rem_next = keep ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], keep};

endmodule

// File: rtl/div_unit.sv
// Multicycle signed/unsigned restoring divider: one quotient bit per cycle, registered results.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t       state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             q_neg, r_neg, dbz_q;
  logic             accept, last_iter, zero_dvs;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  assign accept    = (state == IDLE) && start && !annul;
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign zero_dvs  = (divisor == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs      (dvs_q),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          busy       = 1'b1;
          state_next = zero_dvs ? DONE : BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (annul)          state_next = IDLE;
        else if (last_iter) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Results are written on the DONE->IDLE edge so an annul in DONE can still suppress them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dbz_q       <= 1'b0;
      valid       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= '0;
            dvs_q <= mag(divisor, signed_div);
            quo_q <= mag(dividend, signed_div);
            rem_q <= zero_dvs ? dividend : '0;
            q_neg <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= signed_div & dividend[WIDTH-1];
            dbz_q <= zero_dvs;
          end
        end
        BUSY: begin
          if (annul) begin
            cnt <= '0;
          end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt   <= last_iter ? '0 : cnt + 1'b1;
          end
        end
        DONE: begin
          if (!annul) begin
            valid       <= 1'b1;
            div_by_zero <= dbz_q;
            quotient    <= dbz_q ? '1 : (q_neg ? -quo_q : quo_q);
            remainder   <= dbz_q ? rem_q : (r_neg ? -rem_q : rem_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed divides, annul, reset and start-while-busy cases.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        valid;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int vectors     = 0;
  int miscompares = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_div  (signed_div),
    .annul       (annul),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .valid       (valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one divide and waits (bounded) for valid; reissue>0 pulses a stray start in that busy cycle.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz, input int elat, input int ebusy, input int reissue);
    int lat;
    int busy_cnt;
    lat      = 0;
    busy_cnt = 0;
    @(negedge clk);
    dividend   = a;
    divisor    = b;
    signed_div = s;
    start      = 1'b1;
    #1;
    if (busy) busy_cnt++;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (busy) busy_cnt++;
      start = (n == reissue);
      if (n == reissue) begin
        dividend   = 32'd50;
        divisor    = 32'd5;
        signed_div = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (valid) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(ebusy));
    chk({tag, ".quotient"}, quotient, eq);
    chk({tag, ".remainder"}, remainder, er);
    chk({tag, ".dbz"}, 32'(div_by_zero), 32'(edbz));
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".valid_one_cycle"}, 32'(valid), 32'd0);
    chk({tag, ".quotient_hold"}, quotient, eq);
  endtask

  initial begin
    int vseen;
    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    dividend   = '0;
    divisor    = '0;
    #12;
    chk("reset.quotient", quotient, 32'd0);
    chk("reset.remainder", remainder, 32'd0);
    chk("reset.valid", 32'(valid), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div("divu_100_7",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33, 33, 0);
    do_div("div_m7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33, 33, 0);
    do_div("divu_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0, 33, 33, 0);
    do_div("div_7_m2",    32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 33, 33, 0);
    do_div("divu_big",    32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 32'd1,          32'h7FFF_FFFF,  1'b0, 33, 33, 0);
    do_div("div_by_zero", 32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234,  1'b1,  1,  1, 0);
    do_div("div_min_m1",  32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 33, 33, 0);

    // Annul in the 10th busy cycle: back to IDLE, no valid, previous results kept.
    @(negedge clk);
    dividend   = 32'd100;
    divisor    = 32'd7;
    signed_div = 1'b0;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    chk("annul.busy_idle", 32'(busy), 32'd0);
    vseen = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) vseen++;
    end
    chk("annul.no_valid", 32'(vseen), 32'd0);
    chk("annul.quotient_kept", quotient, 32'h8000_0000);
    do_div("after_annul_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33, 33, 0);

    // Reset in the 20th busy cycle of a divide.
    do_div("divu_100_7b", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 33, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst.quotient", quotient, 32'd0);
    chk("midrst.remainder", remainder, 32'd0);
    chk("midrst.valid", 32'(valid), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    vseen = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) vseen++;
    end
    chk("midrst.no_valid", 32'(vseen), 32'd0);

    // Stray start with different operands in busy cycle 5 must not disturb 100/7.
    do_div("busy_restart", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 33, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
